// File: rtl/res_to_bcd.sv
// res_to_bcd: converts a latched unsigned result (with sign and error flag)
// into six BCD digits plus leading-zero blanking, minus sign and error
// indication for a six-digit display. The conversion is a serial
// double-dabble over CONV_BITS cycles; the display outputs only change
// when a conversion completes.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_start   conversion request, honoured only when idle
//   i_res     unsigned magnitude (WIDTH bits)
//   i_sign    1 = result negative
//   i_err     upstream overflow flag
//   o_busy    conversion in progress
//   o_done    one-cycle pulse when the display outputs are refreshed
//   o_digits  six BCD digits, [23:20] most significant
//   o_blank   leading-zero blanking mask, bit n blanks digit n
//   o_neg     show minus sign
//   o_err     show error indication
module res_to_bcd #(
    parameter int unsigned WIDTH     = 40,
    parameter int unsigned CONV_BITS = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_res,
    input  logic             i_sign,
    input  logic             i_err,
    output logic             o_busy,
    output logic             o_done,
    output logic [23:0]      o_digits,
    output logic [5:0]       o_blank,
    output logic             o_neg,
    output logic             o_err
);

    localparam int unsigned CNT_W   = $clog2(CONV_BITS + 1);
    localparam int unsigned NDIG    = 6;
    localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(999999);
    localparam logic [WIDTH-1:0] MAX_NEG = WIDTH'(99999);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CONV_BITS-1:0]   shift_q;
    logic [23:0]            bcd_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sign_q;
    logic                   fail_q;

    logic                   range_ok_c;
    logic                   accept_c;
    logic                   last_shift_c;
    logic [23:0]            bcd_adj_c;
    logic [NDIG-1:0]        zero_c;
    logic [5:0]             blank_c;

    // Range check on the live inputs; the negative display has one digit
    // fewer because the sign occupies a position.
    assign range_ok_c   = !i_err &&
                          !(i_sign && (i_res > MAX_NEG)) &&
                          !(!i_sign && (i_res > MAX_POS));
    assign accept_c     = (state_q == IDLE) && i_start;
    assign last_shift_c = (cnt_q == CNT_W'(CONV_BITS - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = range_ok_c ? SHIFT : DONE;
            SHIFT:   if (last_shift_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Double-dabble correction: add 3 to every nibble >= 5 before the shift
    always_comb begin
        bcd_adj_c = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    // Leading-zero blanking; the units digit is never blanked
    always_comb begin
        zero_c = '0;
        for (int i = 0; i < NDIG; i++) begin
            zero_c[i] = (bcd_q[4*i +: 4] == 4'd0);
        end
        blank_c    = '0;
        blank_c[5] = zero_c[5];
        blank_c[4] = zero_c[5] & zero_c[4];
        blank_c[3] = zero_c[5] & zero_c[4] & zero_c[3];
        blank_c[2] = zero_c[5] & zero_c[4] & zero_c[3] & zero_c[2];
        blank_c[1] = zero_c[5] & zero_c[4] & zero_c[3] & zero_c[2] & zero_c[1];
    end

    // Conversion datapath: capture on accept, one bit per SHIFT cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else if (accept_c) begin
            shift_q <= i_res[CONV_BITS-1:0];
            bcd_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= i_sign;
            fail_q  <= !range_ok_c;
        end else if (state_q == SHIFT) begin
            bcd_q   <= {bcd_adj_c[22:0], shift_q[CONV_BITS-1]};
            shift_q <= {shift_q[CONV_BITS-2:0], 1'b0};
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // Display outputs: refreshed once per conversion while in DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_digits <= '0;
            o_blank  <= 6'b111110;
            o_neg    <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_busy <= (state_d != IDLE);
            o_done <= (state_q == DONE);
            if (state_q == DONE) begin
                if (fail_q) begin
                    o_digits <= 24'hFFFFFF;
                    o_blank  <= 6'b000000;
                    o_neg    <= 1'b0;
                    o_err    <= 1'b1;
                end else begin
                    o_digits <= bcd_q;
                    o_blank  <= blank_c;
                    o_neg    <= sign_q && (bcd_q != 24'd0);
                    o_err    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/res_to_bcd.md
RES_TO_BCD -- requirements
Module: res_to_bcd

Interface
REQ-001 Parameter WIDTH, default 40, is the width of the binary result input.
REQ-002 Parameter CONV_BITS, default 20, is the number of low-order result bits converted.
REQ-003 i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_start  input  1  request a conversion; sampled only in IDLE.
REQ-006 i_res  input  WIDTH  unsigned magnitude from the subtract/add unit.
REQ-007 i_sign  input  1  1 = result negative.
REQ-008 i_err  input  1  upstream overflow flag.
REQ-009 o_busy  output  1  high while a conversion is in progress (state not IDLE).
REQ-010 o_done  output  1  single-cycle pulse when new outputs are valid.
REQ-011 o_digits  output  24  six BCD digits; [23:20] is the most significant, [3:0] the least significant.
REQ-012 o_blank  output  6  leading-zero blanking mask; bit n = 1 blanks digit n.
REQ-013 o_neg  output  1  display the minus sign.
REQ-014 o_err  output  1  display the error indication.

Function
REQ-015 States: IDLE, SHIFT, DONE.
- IDLE->SHIFT on i_start when range check passes.
- IDLE->DONE on i_start when range check fails.
- SHIFT->DONE after exactly CONV_BITS shift cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-016 On i_start in IDLE, the block shall latch i_res, i_sign and i_err; the inputs are don't-care afterwards.
REQ-017 Range check fails if any of the following holds:
- i_err = 1;
- i_sign = 1 and i_res > 99999;
- i_sign = 0 and i_res > 999999.
REQ-018 SHIFT shall perform double-dabble on i_res[CONV_BITS-1:0], one bit per cycle, MSB first: add 3 to every BCD nibble >= 5, then shift left by one.
REQ-019 Latency: i_start sampled at edge k -> o_done high during the cycle after edge k+CONV_BITS+1 (21 cycles at default); error path -> o_done high after edge k+1.
REQ-020 o_digits, o_blank, o_neg and o_err shall update only on entry to DONE and hold until the next DONE.
REQ-021 Valid result outputs:
- o_err = 0;
- o_neg = latched sign, forced to 0 when the magnitude is 0;
- o_digits = BCD value.
REQ-022 o_blank bit n (n = 5..1) shall be 1 when digit n and all digits above it are 0; bit 0 shall always be 0.
REQ-023 Failed result outputs: o_err = 1, o_neg = 0, o_digits = 24'hFFFFFF, o_blank = 6'b000000.
REQ-024 i_start while o_busy = 1 (SHIFT or DONE) shall be ignored, with no queueing.
REQ-025 i_start held high shall start a new conversion on the first IDLE cycle after DONE.
REQ-026 Intermediate shift and BCD registers shall not be visible on the outputs.

Reset
REQ-027 Asserting i_rst_n = 0 at any time, including mid-SHIFT, shall immediately set:
- state = IDLE;
- o_busy = 0, o_done = 0;
- o_digits = 0, o_blank = 6'b111110;
- o_neg = 0, o_err = 0;
- internal registers = 0.
REQ-028 After deassertion, the first accepted i_start shall behave exactly as from power-up.

Verification
REQ-029 i_res = 123456, i_sign = 0, i_start pulse -> o_busy for 21 cycles, then o_done pulse; o_digits = 24'h123456, o_blank = 000000, o_neg = 0, o_err = 0.
REQ-030 i_res = 42, i_sign = 1 -> o_digits = 24'h000042, o_blank = 111100, o_neg = 1, o_err = 0.
REQ-031 Boundaries:
- i_res = 999999, i_sign = 0 -> valid, digits 999999;
- i_res = 1000000, i_sign = 0 -> o_err = 1, digits FFFFFF, o_done 2 cycles after start;
- i_res = 100000, i_sign = 1 -> o_err = 1.
REQ-032 i_res = 0, i_sign = 1 -> o_neg = 0, o_digits = 0, o_blank = 111110; i_err = 1 with i_res = 5 -> error outputs.
REQ-033 i_start pulsed again during SHIFT -> ignored, exactly one o_done; i_rst_n pulsed low at SHIFT cycle 10 -> all outputs at reset values, no o_done, next conversion correct.
